// File: rtl/cam_pixel_writer.sv
// OV7670 capture back end: packs RGB565 byte pairs into RGB444 pixels and writes them to the frame buffer.
// Optional build macro CAPTURE_DOWNSCALE_EN selects 2x2 decimated storage instead of full resolution.
module cam_pixel_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic              PCLK,
    input  logic [7:0]        D,
    input  logic [9:0]        PIXEL_COLUMN,
    output logic              WE,
    output logic [ADDR_W-1:0] WADDR,
    output logic [11:0]       WDATA,
    output logic [8:0]        ROW,
    output logic              FRAME_DONE,
    output logic              BUSY
);

    typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_t;
    typedef enum logic {BYTE1, BYTE2} phase_t;

    localparam logic [31:0] H_LIM   = 32'(H_ACTIVE);
    localparam logic [31:0] V_LIM   = 32'(V_ACTIVE);
    localparam logic [8:0]  ROW_MAX = 9'd511;

    state_t            state;
    phase_t            phase;
    logic              vsync_d;
    logic              href_d;
    logic              pclk_d;
    logic [7:0]        b1;
    logic              line_has_pix;
    logic [ADDR_W-1:0] line_base;

    logic              byte_edge;
    logic              line_end;
    logic              vs_rise;
    logic              vs_fall;
    logic              href_idle;
    logic              in_bounds;
    logic              write_ok;
    logic              advance_base;
    logic [ADDR_W-1:0] col_ext;
    logic [ADDR_W-1:0] write_addr;
    logic [ADDR_W-1:0] line_step;

    assign byte_edge = !pclk_d && PCLK && HREF && href_d;
    assign line_end  = href_d && !HREF;
    assign vs_rise   = !vsync_d && VSYNC;
    assign vs_fall   = vsync_d && !VSYNC;
    assign href_idle = !HREF && !href_d;

    // Bounds are always judged on full-resolution indices, even when decimating.
    assign col_ext   = ADDR_W'(PIXEL_COLUMN);
    assign in_bounds = (32'(PIXEL_COLUMN) < H_LIM) && (32'(ROW) < V_LIM);

`ifdef CAPTURE_DOWNSCALE_EN
    assign write_ok     = in_bounds && !PIXEL_COLUMN[0] && !ROW[0];
    assign write_addr   = line_base + (col_ext >> 1);
    assign line_step    = ADDR_W'(H_ACTIVE / 2);
    assign advance_base = !ROW[0];
`else
    assign write_ok     = in_bounds;
    assign write_addr   = line_base + col_ext;
    assign line_step    = ADDR_W'(H_ACTIVE);
    assign advance_base = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            phase        <= BYTE1;
            vsync_d      <= 1'b0;
            href_d       <= 1'b0;
            pclk_d       <= 1'b0;
            b1           <= 8'h00;
            line_has_pix <= 1'b0;
            line_base    <= '0;
            WE           <= 1'b0;
            WADDR        <= '0;
            WDATA        <= 12'h000;
            ROW          <= 9'd0;
            FRAME_DONE   <= 1'b0;
            BUSY         <= 1'b0;
        end else begin
            vsync_d    <= VSYNC;
            href_d     <= HREF;
            pclk_d     <= PCLK;
            WE         <= 1'b0;
            FRAME_DONE <= 1'b0;

            case (state)
                IDLE: begin
                    if (START) state <= SYNC;
                end

                // A frame already under way is skipped; capture only begins on a clean VSYNC fall.
                SYNC: begin
                    if (vs_fall) begin
                        ROW          <= 9'd0;
                        line_base    <= '0;
                        phase        <= BYTE1;
                        line_has_pix <= 1'b0;
                        BUSY         <= 1'b1;
                        state        <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (href_idle) begin
                        phase <= BYTE1;
                    end else if (byte_edge) begin
                        if (phase == BYTE1) begin
                            b1    <= D;
                            phase <= BYTE2;
                        end else begin
                            phase        <= BYTE1;
                            line_has_pix <= 1'b1;
                            WDATA        <= {b1[7:4], b1[2:0], D[7], D[4:1]};
                            WE           <= write_ok;
                            if (write_ok) WADDR <= write_addr;
                        end
                    end

                    // Lines that never completed a pixel are HREF glitches and do not count.
                    if (line_end) begin
                        line_has_pix <= 1'b0;
                        if (line_has_pix && ROW != ROW_MAX) begin
                            ROW <= ROW + 9'd1;
                            if (advance_base) line_base <= line_base + line_step;
                        end
                    end

                    if (vs_rise) begin
                        FRAME_DONE <= 1'b1;
                        BUSY       <= 1'b0;
                        state      <= START ? SYNC : IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_pixel_writer.sv
// Self-checking bench for cam_pixel_writer: vector table, frame-level scoreboard and hand-built corner cases.
// Honours CAPTURE_DOWNSCALE_EN in its reference model.
module tb_cam_pixel_writer;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 19;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic          VSYNC;
    logic          HREF;
    logic          PCLK;
    logic [7:0]    D;
    logic [9:0]    PIXEL_COLUMN;
    logic          WE;
    logic [AW-1:0] WADDR;
    logic [11:0]   WDATA;
    logic [8:0]    ROW;
    logic          FRAME_DONE;
    logic          BUSY;

    int n_checks = 0;
    int n_fail   = 0;
    int line_px[16];

    logic [30:0] act_q[$];
    logic [30:0] exp_q[$];

    typedef struct {
        int            row;
        int            col;
        logic [7:0]    b1;
        logic [7:0]    b2;
        bit            we;
        logic [AW-1:0] addr;
        logic [11:0]   data;
    } vec_t;

    vec_t tbl[11];

    cam_pixel_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .VSYNC(VSYNC), .HREF(HREF), .PCLK(PCLK),
        .D(D), .PIXEL_COLUMN(PIXEL_COLUMN), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .ROW(ROW), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (WE === 1'b1) act_q.push_back({WADDR, WDATA});
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Reference model: plain coordinate arithmetic on what the camera sent.
    function automatic bit model_we(input int r, input int c);
`ifdef CAPTURE_DOWNSCALE_EN
        return (c < H) && (r < V) && (c % 2 == 0) && (r % 2 == 0);
`else
        return (c < H) && (r < V);
`endif
    endfunction

    function automatic logic [AW-1:0] model_addr(input int r, input int c);
`ifdef CAPTURE_DOWNSCALE_EN
        return AW'((r / 2) * (H / 2) + c / 2);
`else
        return AW'(r * H + c);
`endif
    endfunction

    function automatic logic [11:0] model_data(input logic [7:0] hi, input logic [7:0] lo);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] bl5;
        r5  = hi[7:3];
        g6  = {hi[2:0], lo[7:5]};
        bl5 = lo[4:0];
        return {r5[4:1], g6[5:2], bl5[4:1]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic href, input logic pclk, input logic [7:0] d);
        HREF = href;
        PCLK = pclk;
        D    = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        applyStimulus(1'b1, 1'b1, b);
        applyStimulus(1'b1, 1'b1, b);
        applyStimulus(1'b1, 1'b0, b);
        applyStimulus(1'b1, 1'b0, b);
    endtask

    task automatic line_start();
        repeat (2) applyStimulus(1'b1, 1'b0, 8'h00);
    endtask

    task automatic line_end();
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    // npx==0 models an HREF glitch carrying a single stray byte.
    task automatic send_line(input int npx, input bit cap, input int row, input bit fixed);
        logic [7:0] hi;
        logic [7:0] lo;
        line_start();
        if (npx == 0) begin
            send_byte(8'($urandom));
        end else begin
            for (int c = 0; c < npx; c++) begin
                PIXEL_COLUMN = 10'(c);
                hi = fixed ? 8'hF8 : 8'($urandom);
                lo = fixed ? 8'h1F : 8'($urandom);
                send_byte(hi);
                send_byte(lo);
                if (cap && model_we(row, c)) exp_q.push_back({model_addr(row, c), model_data(hi, lo)});
            end
        end
        line_end();
    endtask

    task automatic compare_writes();
        int n;
        checkOutput("write_count", 32'(act_q.size()), 32'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput("write_addr", 32'(act_q[i][30:12]), 32'(exp_q[i][30:12]));
            checkOutput("write_data", 32'(act_q[i][11:0]), 32'(exp_q[i][11:0]));
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic end_frame(input bit cap, input int exp_row);
        VSYNC = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("frame_done", 32'(FRAME_DONE), 32'(cap));
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("frame_done_width", 32'(FRAME_DONE), 32'd0);
        checkOutput("busy_after_frame", 32'(BUSY), 32'd0);
        if (cap) checkOutput("row_at_end", 32'(ROW), 32'(exp_row));
        repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);
        compare_writes();
    endtask

    task automatic frame(input bit cap, input int nl, input bit fixed, input int chg_line, input bit chg_val);
        int mrow;
        mrow = 0;
        act_q.delete();
        exp_q.delete();
        VSYNC = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < nl; l++) begin
            send_line(line_px[l], cap, mrow, fixed);
            if (cap && line_px[l] > 0 && mrow < 511) mrow++;
            if (l == 0) checkOutput("busy_mid_frame", 32'(BUSY), 32'(cap));
            if (l == chg_line) START = chg_val;
        end
        end_frame(cap, mrow);
    endtask

    function automatic vec_t mk(input int r, input int c, input logic [7:0] hi, input logic [7:0] lo,
                                input logic [11:0] data);
        vec_t v;
        v.row  = r;
        v.col  = c;
        v.b1   = hi;
        v.b2   = lo;
        v.we   = model_we(r, c);
        v.addr = model_addr(r, c);
        v.data = data;
        return v;
    endfunction

    initial begin
        int cur;
        int nl;

        tbl[0]  = mk(0, 0, 8'hF8, 8'h1F, 12'hF0F);
        tbl[1]  = mk(0, 1, 8'h07, 8'hE0, 12'h0F0);
        tbl[2]  = mk(0, 9, 8'hAA, 8'h55, 12'h000);
        tbl[3]  = mk(1, 0, 8'h00, 8'h00, 12'h000);
        tbl[4]  = mk(1, 4, 8'h5A, 8'hC3, 12'h551);
        tbl[5]  = mk(1, 7, 8'hFF, 8'hFF, 12'hFFF);
        tbl[6]  = mk(2, 3, 8'h07, 8'hE0, 12'h0F0);
        tbl[7]  = mk(2, 8, 8'h12, 8'h34, 12'h000);
        tbl[8]  = mk(3, 7, 8'h81, 8'h42, 12'h821);
        tbl[9]  = mk(4, 0, 8'hF8, 8'h1F, 12'h000);
        tbl[10] = mk(5, 2, 8'hF8, 8'h1F, 12'h000);

        RST = 1'b1; START = 1'b0; VSYNC = 1'b1; HREF = 1'b0; PCLK = 1'b0; D = 8'h00; PIXEL_COLUMN = 10'd0;
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("reset_we", 32'(WE), 32'd0);
        checkOutput("reset_waddr", 32'(WADDR), 32'd0);
        checkOutput("reset_wdata", 32'(WDATA), 32'd0);
        checkOutput("reset_row", 32'(ROW), 32'd0);
        checkOutput("reset_frame_done", 32'(FRAME_DONE), 32'd0);
        checkOutput("reset_busy", 32'(BUSY), 32'd0);
        RST = 1'b0;
        START = 1'b1;
        repeat (4) applyStimulus(1'b0, 1'b0, 8'h00);

        // Vector table: exact write latency, address and colour packing per pixel.
        act_q.delete();
        exp_q.delete();
        VSYNC = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        cur = 0;
        line_start();
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].row != cur) begin
                line_end();
                line_start();
                cur = tbl[i].row;
            end
            PIXEL_COLUMN = 10'(tbl[i].col);
            send_byte(tbl[i].b1);
            applyStimulus(1'b1, 1'b1, tbl[i].b2);
            checkOutput("tbl_we", 32'(WE), 32'(tbl[i].we));
            if (tbl[i].we) begin
                checkOutput("tbl_waddr", 32'(WADDR), 32'(tbl[i].addr));
                checkOutput("tbl_wdata", 32'(WDATA), 32'(tbl[i].data));
                exp_q.push_back({tbl[i].addr, tbl[i].data});
            end
            applyStimulus(1'b1, 1'b1, tbl[i].b2);
            checkOutput("tbl_we_pulse", 32'(WE), 32'd0);
            applyStimulus(1'b1, 1'b0, tbl[i].b2);
            applyStimulus(1'b1, 1'b0, tbl[i].b2);
        end
        line_end();
        end_frame(1'b1, cur + 1);

        // Full 4x8 frame of solid red+blue.
        for (int l = 0; l < 4; l++) line_px[l] = 8;
        frame(1'b1, 4, 1'b1, -1, 1'b0);

        // Random frames with glitch lines, over-wide lines and over-tall frames.
        for (int f = 0; f < 12; f++) begin
            nl = 1 + int'($urandom_range(6));
            for (int l = 0; l < nl; l++) line_px[l] = int'($urandom_range(10));
            frame(1'b1, nl, 1'b0, -1, 1'b0);
        end

        // START dropped mid-frame: frame completes, then the block idles through the next one.
        for (int l = 0; l < 4; l++) line_px[l] = 3 + l;
        frame(1'b1, 4, 1'b0, 1, 1'b0);
        frame(1'b0, 2, 1'b0, -1, 1'b0);

        // START raised mid-frame: that frame is skipped, the next is captured.
        frame(1'b0, 3, 1'b0, 0, 1'b1);
        frame(1'b1, 3, 1'b0, -1, 1'b0);

        // Reset during pixel 13 (row 1, column 5), then a clean restart at address 0.
        act_q.delete();
        exp_q.delete();
        VSYNC = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
        send_line(8, 1'b1, 0, 1'b0);
        line_start();
        for (int c = 0; c < 5; c++) begin
            PIXEL_COLUMN = 10'(c);
            send_byte(8'hF8);
            send_byte(8'h1F);
            exp_q.push_back({model_addr(1, c), 12'hF0F});
        end
        PIXEL_COLUMN = 10'd5;
        send_byte(8'h07);
        RST = 1'b1;
        applyStimulus(1'b1, 1'b1, 8'hE0);
        RST = 1'b0;
        checkOutput("midreset_we", 32'(WE), 32'd0);
        checkOutput("midreset_waddr", 32'(WADDR), 32'd0);
        checkOutput("midreset_wdata", 32'(WDATA), 32'd0);
        checkOutput("midreset_row", 32'(ROW), 32'd0);
        checkOutput("midreset_frame_done", 32'(FRAME_DONE), 32'd0);
        checkOutput("midreset_busy", 32'(BUSY), 32'd0);
        for (int c = 6; c < 8; c++) begin
            PIXEL_COLUMN = 10'(c);
            send_byte(8'hF8);
            send_byte(8'h1F);
        end
        line_end();
        send_line(8, 1'b0, 2, 1'b0);
        end_frame(1'b0, 0);
        for (int l = 0; l < 4; l++) line_px[l] = 8;
        frame(1'b1, 4, 1'b0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
